// File: rtl/stream_cat_pkg.sv
// -----------------------------------------------------------------------------
// stream_cat_pkg
// Shared constants and helpers for the clocked stream concatenator.
//   - DEF_*        : default parameter values of the block
//   - PTR_W        : FIFO pointer width for the default FIFO depth
//   - SKEW_CNT_W   : skew counter width for the default timeout
//   - ptr_width()  : pointer width for an arbitrary power-of-two depth
//   - cnt_width()  : counter width able to hold 0..timeout
//   - lane_lsb()   : LSB position of a lane inside a packed multi-lane bus
// -----------------------------------------------------------------------------
package stream_cat_pkg;

    localparam int DEF_N_CH         = 12;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_SKEW_TIMEOUT = 64;

    // Index width of a power-of-two FIFO; at least one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width needed to count from 0 up to and including timeout.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    // Lane i of a bus of width-bit lanes starts at bit i*width.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    localparam int PTR_W      = ptr_width(DEF_FIFO_DEPTH);
    localparam int SKEW_CNT_W = cnt_width(DEF_SKEW_TIMEOUT);

endpackage

// File: rtl/stream_cat_fifo.sv
// -----------------------------------------------------------------------------
// stream_cat_fifo
// Small register FIFO, first-word-fall-through, with synchronous clear.
// One instance buffers one input channel of the concatenator.
//
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (FIFO empty)
//   clr_i    : synchronous clear, wins over push and pop
//   push_i   : write din_i (ignored when full)
//   pop_i    : discard head entry (ignored when empty)
//   din_i    : write data
//   dout_o   : head entry, valid whenever empty_o is low
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
// -----------------------------------------------------------------------------
module stream_cat_fifo
    import stream_cat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    // The default depth resolves to the package constant.
    localparam int AW = (DEPTH == DEF_FIFO_DEPTH) ? PTR_W : ptr_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i & ~full_o  & ~clr_i;
    assign do_pop  = pop_i  & ~empty_o & ~clr_i;

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/stream_cat_sync.sv
// -----------------------------------------------------------------------------
// stream_cat_sync
// Joins N_CH AXI-Stream slave channels of DATA_W bits into one master word of
// N_CH*DATA_W bits. Every output word carries exactly one beat from each
// enabled channel; per-channel FIFOs absorb inter-channel skew.
//
// Handshake semantics (both sides): a beat transfers at a rising aclk edge
// where TVALID and TREADY are both high. The master side keeps TVALID and
// TDATA stable while TVALID is high and TREADY is low.
//
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset
//   S_AXIS_TDATA    : channel i in bits [i*DATA_W +: DATA_W]
//   S_AXIS_TVALID   : per-channel valid
//   S_AXIS_TREADY   : per-channel ready (disabled channels always ready)
//   M_AXIS_TDATA    : joined word, channel 0 in the LSBs, disabled lanes 0
//   M_AXIS_TVALID   : output valid
//   M_AXIS_TREADY   : downstream ready
//   ch_en           : channel enable mask, expected to change only when idle
//   clr_err         : pulse, clears skew_err
//   skew_err        : sticky, set after SKEW_TIMEOUT cycles of sustained skew
//   out_count       : number of master-side handshakes, wraps at 2^32
// -----------------------------------------------------------------------------
module stream_cat_sync
    import stream_cat_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int SKEW_TIMEOUT = DEF_SKEW_TIMEOUT
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [N_CH*DATA_W-1:0] S_AXIS_TDATA,
    input  logic [N_CH-1:0]        S_AXIS_TVALID,
    output logic [N_CH-1:0]        S_AXIS_TREADY,
    output logic [N_CH*DATA_W-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    input  logic [N_CH-1:0]        ch_en,
    input  logic                   clr_err,
    output logic                   skew_err,
    output logic [31:0]            out_count
);

    localparam int W  = N_CH * DATA_W;
    // The default timeout resolves to the package constant.
    localparam int CW = (SKEW_TIMEOUT == DEF_SKEW_TIMEOUT) ? SKEW_CNT_W
                                                           : cnt_width(SKEW_TIMEOUT);
    localparam logic [CW-1:0] SKEW_MAX = CW'(SKEW_TIMEOUT);

    // Ready is held off until the first edge after reset release so no beat
    // can be accepted in the same cycle the reset deasserts.
    logic ready_en_q;

    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] push;
    logic [N_CH-1:0] fifo_pop;
    logic [W-1:0]    joined;

    logic join_ok;
    logic pop;
    logic m_hs;

    logic [W-1:0]  tdata_q;
    logic [W-1:0]  tdata_d;
    logic          tvalid_q;
    logic          tvalid_d;

    logic          skew;
    logic [CW-1:0] skew_cnt_q;
    logic [CW-1:0] skew_cnt_d;
    logic          skew_err_q;
    logic          skew_err_d;

    logic [31:0]   count_q;
    logic [31:0]   count_d;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    // A disabled channel is always ready and its beats are dropped (sink).
    assign S_AXIS_TREADY = {N_CH{ready_en_q}} & (~ch_en | ~full);
    assign push          = S_AXIS_TVALID & S_AXIS_TREADY & ch_en;

    // ------------------------------------------------------------------
    // Join: a word forms only when every enabled channel has a head entry
    // ------------------------------------------------------------------
    assign join_ok  = (|ch_en) & (&(~ch_en | ~empty));
    assign m_hs     = tvalid_q & M_AXIS_TREADY;
    assign pop      = join_ok & (~tvalid_q | M_AXIS_TREADY);
    assign fifo_pop = {N_CH{pop}} & ch_en;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        logic [DATA_W-1:0] lane_dout;

        stream_cat_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (aclk),
            .rst_ni  (aresetn),
            .clr_i   (~ch_en[i]),
            .push_i  (push[i]),
            .pop_i   (fifo_pop[i]),
            .din_i   (S_AXIS_TDATA[lane_lsb(i, DATA_W) +: DATA_W]),
            .dout_o  (lane_dout),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );

        assign joined[lane_lsb(i, DATA_W) +: DATA_W] = ch_en[i] ? lane_dout : '0;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        if (pop) begin
            tdata_d  = joined;
            tvalid_d = 1'b1;
        end else if (m_hs) begin
            // Word consumed and nothing new: drop valid, keep last data.
            tvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Skew monitor: some enabled FIFO full while another is empty
    // ------------------------------------------------------------------
    assign skew = (|(ch_en & full)) & (|(ch_en & empty));

    always_comb begin
        skew_cnt_d = '0;
        if (skew) begin
            skew_cnt_d = (skew_cnt_q == SKEW_MAX) ? skew_cnt_q : skew_cnt_q + 1'b1;
        end
    end

    // Once saturated with skew still present the set term stays active, so a
    // clear pulse during sustained skew has no effect (set wins).
    always_comb begin
        skew_err_d = skew_err_q;
        if (clr_err) begin
            skew_err_d = 1'b0;
        end
        if (skew && (skew_cnt_d == SKEW_MAX)) begin
            skew_err_d = 1'b1;
        end
    end

    assign count_d = count_q + {31'd0, m_hs};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            skew_cnt_q <= '0;
            skew_err_q <= 1'b0;
            count_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            skew_cnt_q <= skew_cnt_d;
            skew_err_q <= skew_err_d;
            count_q    <= count_d;
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign skew_err      = skew_err_q;
    assign out_count     = count_q;

endmodule
